// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the IF stage.
// No logic: latency not applicable.
// No flow control: definitions only.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic in-order FIFO with synchronous flush, parameterized by element type and depth.
// Latency: a pushed element is visible at head_o the cycle after the push.
// Backpressure: none internally; callers must respect count_o (overflow/underflow are assertion errors).
module fetch_fifo #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  T                 push_dat_i,
  input  logic             pop_i,
  output T                 head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Pointer and occupancy tracking; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage needs no reset; the count qualifies every read.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  // Push into a full FIFO without a same-cycle pop means the credit accounting broke.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(push_i && !pop_i && !flush_i && count_q == CNT_W'(DEPTH)));

  // Pop from an empty FIFO means a response arrived with nothing outstanding.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(pop_i && !flush_i && count_q == '0));

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns fetch PC, issues credit-limited imem requests, queues responses, drives the ID register.
// Latency: response to ID register is 1 cycle when the queue is empty and ID is free; otherwise queued.
// Backpressure: stall_i holds ID; requests stop when outstanding+queued reaches QUEUE_DEPTH.
// Optional: FETCH_MISALIGN_CHECK_EN adds fetch_misaligned_o and a sticky halt on misaligned redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        fetch_misaligned_o,
`endif
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o
);

  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             id_valid_q, id_valid_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic [31:0]      id_instr_q, id_instr_d;

  logic [CNT_W-1:0] trk_count, q_count;
  logic [31:0]      trk_head;
  logic             q_empty, unused_trk_empty;
  fetch_entry_t     q_head, q_in;

  logic             halted, credit_ok, hs, resp_live, q_take, bypass, enq;
  logic [31:0]      redirect_tgt;

  // The low two target bits never reach the PC; with the check enabled they trigger a halt instead.
  assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halt_q;

  // Sticky halt on a misaligned redirect; only reset clears it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                               halt_q <= 1'b0;
    else if (redirect_i && |redirect_pc_i[1:0])   halt_q <= 1'b1;
  end

  assign halted             = halt_q;
  assign fetch_misaligned_o = halt_q;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc_i[1:0];
  assign halted        = 1'b0;
`endif

  // Credit counts both in-flight requests and queued entries so the queue can never overflow.
  assign credit_ok        = ({1'b0, trk_count} + {1'b0, q_count}) < SUM_W'(QUEUE_DEPTH);
  assign imem_req_valid_o = reset_n_i && credit_ok && !redirect_i && !halted;
  assign imem_req_addr_o  = fetch_pc_q;
  assign hs               = imem_req_valid_o && imem_req_ready_i;

  // A response is live only once all stale responses have been drained.
  assign resp_live = imem_resp_valid_i && (drop_q == '0);
  assign q_take    = !redirect_i && !stall_i && !q_empty && !halted;
  assign bypass    = !redirect_i && !stall_i && q_empty && resp_live && !halted;
  assign enq       = resp_live && !redirect_i && !bypass;
  assign q_in      = '{pc: trk_head, instr: imem_resp_data_i};

  fetch_fifo #(.T(logic [31:0]), .DEPTH(QUEUE_DEPTH), .CNT_W(CNT_W)) u_trk_fifo (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .flush_i    (redirect_i),
    .push_i     (hs),
    .push_dat_i (fetch_pc_q),
    .pop_i      (resp_live),
    .head_o     (trk_head),
    .count_o    (trk_count),
    .empty_o    (unused_trk_empty)
  );

  fetch_fifo #(.T(fetch_entry_t), .DEPTH(QUEUE_DEPTH), .CNT_W(CNT_W)) u_instr_queue (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .flush_i    (redirect_i),
    .push_i     (enq),
    .push_dat_i (q_in),
    .pop_i      (q_take),
    .head_o     (q_head),
    .count_o    (q_count),
    .empty_o    (q_empty)
  );

  // Next-state for fetch PC, stale-response counter and the ID register.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_tgt;
      // Everything still in flight becomes stale; a response arriving now is already accounted for.
      drop_d     = drop_q + trk_count + CNT_W'(hs) - CNT_W'(imem_resp_valid_i);
    end else begin
      if (hs) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_resp_valid_i && drop_q != '0) drop_d = drop_q - 1'b1;
    end

    if (redirect_i) begin
      id_valid_d = 1'b0;
    end else if (stall_i) begin
      id_valid_d = id_valid_q;
    end else if (q_take) begin
      id_valid_d = 1'b1;
      id_pc_d    = q_head.pc;
      id_instr_d = q_head.instr;
    end else if (bypass) begin
      id_valid_d = 1'b1;
      id_pc_d    = trk_head;
      id_instr_d = imem_resp_data_i;
    end else begin
      id_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_instr_q <= NOP_INSTR;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  assign id_valid_o = id_valid_q;
  assign id_pc_o    = id_pc_q;
  assign id_instr_o = id_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit (default build): directed scenarios then random traffic.
// The reference model tracks the expected in-order PC streams for requests and ID loads.
// Memory model responds in order with a per-request latency and is never back-pressured.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;

  fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk_i             (clk_i),
    .reset_n_i         (reset_n_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .stall_i           (stall_i),
    .id_valid_o        (id_valid_o),
    .id_pc_o           (id_pc_o),
    .id_instr_o        (id_instr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  int          cyc, checks, errors, live, loads;
  logic [31:0] exp_req_pc, exp_id_pc, last_pc;
  bit          last_valid, expect_stream;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    exp_req_pc    = RST_PC;
    exp_id_pc     = RST_PC;
    live          = 0;
    last_valid    = 1'b0;
    expect_stream = 1'b0;
  endtask

  // One clock of stimulus; entered and left just after a falling edge.
  task automatic cycle(input bit rdy, input bit stl, input bit rdr,
                       input logic [31:0] tgt, input int lat);
    bit          resp_v, hs;
    logic [31:0] haddr, tal;
    imem_req_ready_i  = rdy;
    stall_i           = stl;
    redirect_i        = rdr;
    redirect_pc_i     = tgt;
    resp_v            = (memq.size() != 0) && (memq[0].due <= cyc + 1);
    imem_resp_valid_i = resp_v;
    imem_resp_data_i  = resp_v ? instr_of(memq[0].pc) : 32'h0;
    #1;
    if (rdr) chk("req_vld_in_redirect", 32'(imem_req_valid_o), 32'd0);
    hs    = imem_req_valid_o && rdy;
    haddr = imem_req_addr_o;
    if (hs) chk("req_addr", haddr, exp_req_pc);
    @(posedge clk_i);
    cyc++;
    if (resp_v) void'(memq.pop_front());
    if (hs) begin
      memq.push_back('{pc: haddr, due: cyc + lat});
      exp_req_pc += 32'd4;
      live++;
    end
    if (rdr) begin
      tal        = {tgt[31:2], 2'b00};
      exp_req_pc = tal;
      exp_id_pc  = tal;
      live       = 0;
    end
    @(negedge clk_i);
    if (rdr) begin
      chk("id_vld_after_redirect", 32'(id_valid_o), 32'd0);
      last_valid = 1'b0;
    end else if (stl) begin
      chk("hold_vld", 32'(id_valid_o), 32'(last_valid));
      if (last_valid) begin
        chk("hold_pc", id_pc_o, last_pc);
        chk("hold_instr", id_instr_o, instr_of(last_pc));
      end
    end else begin
      if (expect_stream) chk("stream_vld", 32'(id_valid_o), 32'd1);
      if (id_valid_o) begin
        chk("id_pc", id_pc_o, exp_id_pc);
        chk("id_instr", id_instr_o, instr_of(exp_id_pc));
        last_pc    = exp_id_pc;
        exp_id_pc += 32'd4;
        last_valid = 1'b1;
        live--;
        loads++;
      end else begin
        last_valid = 1'b0;
      end
    end
    chk("credit", 32'(live <= DEPTH), 32'd1);
  endtask

  initial begin
    int loads_before;
    checks = 0; errors = 0; cyc = 0; loads = 0; last_pc = '0;
    reset_n_i = 1'b1; imem_req_ready_i = 1'b0; imem_resp_valid_i = 1'b0;
    imem_resp_data_i = '0; redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0;
    model_reset();
    #1 reset_n_i = 1'b0;
    @(negedge clk_i);
    chk("rst_req_vld", 32'(imem_req_valid_o), 32'd0);
    chk("rst_id_vld", 32'(id_valid_o), 32'd0);
    chk("rst_id_pc", id_pc_o, 32'h0);
    chk("rst_id_instr", id_instr_o, NOP_INSTR);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // Zero-wait memory: one request and one ID load per cycle once filled.
    for (int i = 0; i < 12; i++) begin
      expect_stream = (i >= 2);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
    end
    expect_stream = 1'b0;

    // Stall for three cycles, then release.
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);

    // Slow memory with requests outstanding, redirect to 0x200.
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0, 3);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0200, 3);
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0, 3);

    // Redirect together with a response and stall.
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1);
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);

    // PC wrap and misaligned target (low bits forced to zero).
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1);
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0102, 1);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);

    // Reset in the middle of a burst.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0, 3);
    #2 reset_n_i = 1'b0;
    #1;
    chk("midrst_id_vld", 32'(id_valid_o), 32'd0);
    chk("midrst_req_vld", 32'(imem_req_valid_o), 32'd0);
    @(negedge clk_i);
    model_reset();
    imem_resp_valid_i = 1'b0; redirect_i = 1'b0; stall_i = 1'b0;
    reset_n_i = 1'b1;
    #1;
    chk("post_reset_req_vld", 32'(imem_req_valid_o), 32'd1);
    chk("post_reset_addr", imem_req_addr_o, RST_PC);
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0, 2);

    // Random traffic against the in-order model.
    loads_before = loads;
    for (int i = 0; i < 600; i++) begin
      bit rdy, stl, rdr;
      rdy = ($urandom_range(0, 3) != 0);
      stl = ($urandom_range(0, 3) == 0);
      rdr = (memq.size() <= 3) && ($urandom_range(0, 19) == 0);
      cycle(rdy, stl, rdr, $urandom, $urandom_range(1, 4));
    end
    chk("random_progress", 32'((loads - loads_before) > 60), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
